// File: rtl/serial_input_comparator.sv
// Bit-serial magnitude comparator: consumes two MSB-first operand streams under
// a valid/ready handshake and returns less/equal/greater under a second one.
module serial_input_comparator #(
   parameter int n      = 3,
   parameter int SIGNED = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic frame_start,
   input  logic bit_valid,
   input  logic a_bit,
   input  logic b_bit,
   output logic bit_ready,
   output logic decided,
   output logic busy,
   output logic result_valid,
   input  logic result_ready,
   output logic less_than,
   output logic equal_to,
   output logic greater_than
);

   localparam int              CW       = $clog2(n + 2);
   localparam logic [CW-1:0]   CNT_LOAD = CW'(n + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RECV = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam logic [1:0] REL_EQ = 2'd0;
   localparam logic [1:0] REL_LT = 2'd1;
   localparam logic [1:0] REL_GT = 2'd2;

   logic [1:0]    state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [1:0]    rel_reg, rel_next;
   logic          decided_reg, decided_next;
   logic          beat;
   logic          first_beat;
   logic          a_wins;

   // A frame_start in RECV restarts the frame, so a coincident bit pair is dropped.
   assign beat       = bit_valid && (state_reg == ST_RECV) && !frame_start;
   assign first_beat = (cnt_reg == CNT_LOAD);
   // In two's complement the first bit is the sign: a set sign bit makes A the smaller.
   assign a_wins     = (SIGNED != 0 && first_beat) ? ~a_bit : a_bit;

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      rel_next     = rel_reg;
      decided_next = decided_reg;
      case (state_reg)
         ST_IDLE: begin
            if (frame_start) begin
               state_next   = ST_RECV;
               cnt_next     = CNT_LOAD;
               rel_next     = REL_EQ;
               decided_next = 1'b0;
            end
         end
         ST_RECV: begin
            if (frame_start) begin
               cnt_next     = CNT_LOAD;
               rel_next     = REL_EQ;
               decided_next = 1'b0;
            end else if (beat) begin
               if (cnt_reg != '0)
                  cnt_next = cnt_reg - 1'b1;
               if (rel_reg == REL_EQ && (a_bit ^ b_bit)) begin
                  rel_next     = a_wins ? REL_GT : REL_LT;
                  decided_next = 1'b1;
               end
               if (cnt_reg <= CW'(1))
                  state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // The result stays put until it is consumed; only then may a new frame load.
            if (result_ready) begin
               decided_next = 1'b0;
               rel_next     = REL_EQ;
               cnt_next     = '0;
               if (frame_start) begin
                  state_next = ST_RECV;
                  cnt_next   = CNT_LOAD;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            state_next   = ST_IDLE;
            cnt_next     = '0;
            rel_next     = REL_EQ;
            decided_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         rel_reg     <= REL_EQ;
         decided_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         rel_reg     <= rel_next;
         decided_reg <= decided_next;
      end
   end

   assign bit_ready    = (state_reg == ST_RECV);
   assign busy         = (state_reg != ST_IDLE);
   assign result_valid = (state_reg == ST_HOLD);
   assign decided      = decided_reg;
   assign less_than    = result_valid && (rel_reg == REL_LT);
   assign equal_to     = result_valid && (rel_reg == REL_EQ);
   assign greater_than = result_valid && (rel_reg == REL_GT);

endmodule

// File: tb/tb_serial_input_comparator.sv
// Directed bench for serial_input_comparator; an unsigned and a signed instance
// share all inputs so the sign-bit handling can be compared side by side.
module tb_serial_input_comparator;

   logic clk;
   logic reset;
   logic frame_start;
   logic bit_valid;
   logic a_bit;
   logic b_bit;
   logic result_ready;

   logic br_u, dec_u, busy_u, rv_u, lt_u, eq_u, gt_u;
   logic br_s, dec_s, busy_s, rv_s, lt_s, eq_s, gt_s;
   logic [6:0] out_u, out_s;

   int vectors = 0;
   int errors  = 0;

   // Packed as {bit_ready, decided, busy, result_valid, less_than, equal_to, greater_than}
   assign out_u = {br_u, dec_u, busy_u, rv_u, lt_u, eq_u, gt_u};
   assign out_s = {br_s, dec_s, busy_s, rv_s, lt_s, eq_s, gt_s};

   serial_input_comparator #(.n(3), .SIGNED(0)) dut_u (
      .clk(clk), .reset(reset), .frame_start(frame_start), .bit_valid(bit_valid),
      .a_bit(a_bit), .b_bit(b_bit), .bit_ready(br_u), .decided(dec_u), .busy(busy_u),
      .result_valid(rv_u), .result_ready(result_ready), .less_than(lt_u),
      .equal_to(eq_u), .greater_than(gt_u)
   );

   serial_input_comparator #(.n(3), .SIGNED(1)) dut_s (
      .clk(clk), .reset(reset), .frame_start(frame_start), .bit_valid(bit_valid),
      .a_bit(a_bit), .b_bit(b_bit), .bit_ready(br_s), .decided(dec_s), .busy(busy_s),
      .result_valid(rv_s), .result_ready(result_ready), .less_than(lt_s),
      .equal_to(eq_s), .greater_than(gt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic send_bit(input logic a, input logic b);
      bit_valid = 1'b1;
      a_bit     = a;
      b_bit     = b;
      step();
      bit_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      if (out_u !== 7'b0000000) begin errors++; $display("FAIL reset_u: got %b want %b", out_u, 7'b0000000); end
      vectors++;
      if (out_s !== 7'b0000000) begin errors++; $display("FAIL reset_s: got %b want %b", out_s, 7'b0000000); end
      vectors++;
      step();
      step();
      reset = 1'b1;
      step();
      if (out_u !== 7'b0000000) begin errors++; $display("FAIL post_reset_idle: got %b want %b", out_u, 7'b0000000); end
      vectors++;
   endtask

   task automatic test_unsigned_gt();
      logic [3:0] a, b;
      a = 4'b1010;
      b = 4'b1001;
      result_ready = 1'b1;
      start_frame();
      if (out_u !== 7'b1010000) begin errors++; $display("FAIL gt_recv_entry: got %b want %b", out_u, 7'b1010000); end
      vectors++;
      for (int i = 3; i >= 0; i--) begin
         send_bit(a[i], b[i]);
         if (i == 3 || i == 2) begin
            if (out_u !== 7'b1010000) begin errors++; $display("FAIL gt_beat%0d: got %b want %b", 4 - i, out_u, 7'b1010000); end
            vectors++;
         end else if (i == 1) begin
            if (out_u !== 7'b1110000) begin errors++; $display("FAIL gt_decided: got %b want %b", out_u, 7'b1110000); end
            vectors++;
         end else begin
            if (out_u !== 7'b0111001) begin errors++; $display("FAIL gt_result: got %b want %b", out_u, 7'b0111001); end
            vectors++;
         end
      end
      step();
      if (out_u !== 7'b0000000) begin errors++; $display("FAIL gt_back_idle: got %b want %b", out_u, 7'b0000000); end
      vectors++;
   endtask

   task automatic test_gap_equal();
      start_frame();
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b1);
      for (int g = 0; g < 2; g++) begin
         a_bit = 1'b1;
         b_bit = 1'b0;
         step();
         if (out_u !== 7'b1010000) begin errors++; $display("FAIL gap_cycle%0d: got %b want %b", g, out_u, 7'b1010000); end
         vectors++;
      end
      send_bit(1'b1, 1'b1);
      if (out_u !== 7'b1010000) begin errors++; $display("FAIL gap_beat3: got %b want %b", out_u, 7'b1010000); end
      vectors++;
      send_bit(1'b0, 1'b0);
      if (out_u !== 7'b0011010) begin errors++; $display("FAIL gap_equal: got %b want %b", out_u, 7'b0011010); end
      vectors++;
      step();
      if (out_u !== 7'b0000000) begin errors++; $display("FAIL gap_back_idle: got %b want %b", out_u, 7'b0000000); end
      vectors++;
   endtask

   task automatic test_hold_stall();
      logic [3:0] a, b;
      a = 4'b0011;
      b = 4'b0101;
      result_ready = 1'b0;
      start_frame();
      for (int i = 3; i >= 0; i--) send_bit(a[i], b[i]);
      if (out_u !== 7'b0111100) begin errors++; $display("FAIL stall_result: got %b want %b", out_u, 7'b0111100); end
      vectors++;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) frame_start = 1'b1;
         step();
         frame_start = 1'b0;
         if (out_u !== 7'b0111100) begin errors++; $display("FAIL stall_hold%0d: got %b want %b", c, out_u, 7'b0111100); end
         vectors++;
      end
      result_ready = 1'b1;
      step();
      if (out_u !== 7'b0000000) begin errors++; $display("FAIL stall_release: got %b want %b", out_u, 7'b0000000); end
      vectors++;
   endtask

   task automatic test_signed();
      logic [3:0] a, b;
      a = 4'b1000;
      b = 4'b0111;
      start_frame();
      send_bit(a[3], b[3]);
      if (out_u !== 7'b1110000) begin errors++; $display("FAIL signed_dec_u: got %b want %b", out_u, 7'b1110000); end
      vectors++;
      if (out_s !== 7'b1110000) begin errors++; $display("FAIL signed_dec_s: got %b want %b", out_s, 7'b1110000); end
      vectors++;
      for (int i = 2; i >= 0; i--) send_bit(a[i], b[i]);
      if (out_s !== 7'b0111100) begin errors++; $display("FAIL signed_lt: got %b want %b", out_s, 7'b0111100); end
      vectors++;
      if (out_u !== 7'b0111001) begin errors++; $display("FAIL unsigned_gt: got %b want %b", out_u, 7'b0111001); end
      vectors++;
      step();
   endtask

   task automatic test_abort();
      logic [3:0] a, b;
      a = 4'b0001;
      b = 4'b0010;
      start_frame();
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      if (out_u !== 7'b1110000) begin errors++; $display("FAIL abort_pre: got %b want %b", out_u, 7'b1110000); end
      vectors++;
      // Restart with a conflicting beat in the same cycle; that beat must vanish.
      frame_start = 1'b1;
      send_bit(1'b1, 1'b0);
      frame_start = 1'b0;
      if (out_u !== 7'b1010000) begin errors++; $display("FAIL abort_restart: got %b want %b", out_u, 7'b1010000); end
      vectors++;
      for (int i = 3; i >= 0; i--) begin
         send_bit(a[i], b[i]);
         if (i == 2) begin
            if (out_u !== 7'b1010000) begin errors++; $display("FAIL abort_beat2: got %b want %b", out_u, 7'b1010000); end
            vectors++;
         end
      end
      if (out_u !== 7'b0111100) begin errors++; $display("FAIL abort_lt: got %b want %b", out_u, 7'b0111100); end
      vectors++;
      step();
   endtask

   task automatic test_back_to_back();
      bit_valid = 1'b1;
      a_bit     = 1'b1;
      b_bit     = 1'b0;
      step();
      bit_valid = 1'b0;
      if (out_u !== 7'b0000000) begin errors++; $display("FAIL idle_ignores_bits: got %b want %b", out_u, 7'b0000000); end
      vectors++;
      start_frame();
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      if (out_u !== 7'b0111001) begin errors++; $display("FAIL b2b_first: got %b want %b", out_u, 7'b0111001); end
      vectors++;
      start_frame();
      if (out_u !== 7'b1010000) begin errors++; $display("FAIL b2b_reload: got %b want %b", out_u, 7'b1010000); end
      vectors++;
      for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
      if (out_u !== 7'b0011010) begin errors++; $display("FAIL b2b_second: got %b want %b", out_u, 7'b0011010); end
      vectors++;
      step();
   endtask

   task automatic test_async_reset();
      start_frame();
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      if (out_u !== 7'b0000000) begin errors++; $display("FAIL async_reset_u: got %b want %b", out_u, 7'b0000000); end
      vectors++;
      if (out_s !== 7'b0000000) begin errors++; $display("FAIL async_reset_s: got %b want %b", out_s, 7'b0000000); end
      vectors++;
      step();
      reset = 1'b1;
      step();
      start_frame();
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b0);
      if (out_u !== 7'b0111001) begin errors++; $display("FAIL after_reset_gt: got %b want %b", out_u, 7'b0111001); end
      vectors++;
      step();
      if (out_u !== 7'b0000000) begin errors++; $display("FAIL after_reset_idle: got %b want %b", out_u, 7'b0000000); end
      vectors++;
   endtask

   initial begin
      reset        = 1'b0;
      frame_start  = 1'b0;
      bit_valid    = 1'b0;
      a_bit        = 1'b0;
      b_bit        = 1'b0;
      result_ready = 1'b1;
      test_reset();
      test_unsigned_gt();
      test_gap_equal();
      test_hold_stall();
      test_signed();
      test_abort();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
